// File: rtl/sram_ctrl.sv
// sram_ctrl: registered strobe sequencer between a valid/ready core port
// and an external asynchronous SRAM. Every SRAM-side output comes straight
// from a flop, so the strobes cannot glitch.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | strobes inactive, req_ready high, waiting for a request
// S_RD       | ce_n/oe_n low for RD_WAIT+1 cycles, data captured on exit
// S_TURN     | strobes inactive for TURNAROUND cycles after a read
// S_WR_SETUP | ce_n low, data and byte lanes driven, we_n still high
// S_WR_PULSE | we_n low for WR_WAIT+1 cycles
// S_WR_HOLD  | we_n high again, data held one more cycle
module sram_ctrl #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RD_WAIT    = 1,
  parameter int unsigned WR_WAIT    = 1,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_W-1:0]     req_adr_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  input  logic [DATA_W/8-1:0]   req_be_i,
  output logic                  rsp_valid_o,
  output logic [DATA_W-1:0]     rsp_rdata_o,
  output logic                  sram_ce_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o,
  output logic [DATA_W/8-1:0]   sram_be_n_o,
  output logic [ADDR_W-1:0]     sram_adr_o,
  output logic [DATA_W-1:0]     sram_dq_o,
  output logic                  sram_dq_oe_o,
  input  logic [DATA_W-1:0]     sram_dq_i
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned WAIT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  // The counter also holds the turnaround reload, so size it for the largest
  // value it can ever be loaded with.
  localparam int unsigned LOAD_MAX = (WAIT_MAX > TURNAROUND) ? WAIT_MAX : TURNAROUND;
  localparam int unsigned CNT_W    = $clog2(LOAD_MAX + 2);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t RD_LOAD   = cnt_t'(RD_WAIT);
  localparam cnt_t WR_LOAD   = cnt_t'(WR_WAIT);
  localparam cnt_t TURN_LOAD = cnt_t'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_TURN,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_e;

  state_e              state_q;
  cnt_t                cnt_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                ce_n_q;
  logic                oe_n_q;
  logic                we_n_q;
  logic [BE_W-1:0]     be_n_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [DATA_W-1:0]   dq_o_q;
  logic                dq_oe_q;

  // Sequencer: state, wait counter and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= '1;
      adr_q       <= '0;
      dq_o_q      <= '0;
      dq_oe_q     <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            adr_q       <= req_adr_i;
            ce_n_q      <= 1'b0;
            if (req_write_i) begin
              state_q <= S_WR_SETUP;
              be_n_q  <= ~req_be_i;
              dq_o_q  <= req_wdata_i;
              dq_oe_q <= 1'b1;
            end else begin
              state_q <= S_RD;
              oe_n_q  <= 1'b0;
              be_n_q  <= '0;
              cnt_q   <= RD_LOAD;
            end
          end
        end
        S_RD: begin
          if (cnt_q == '0) begin
            rsp_rdata_q <= sram_dq_i;
            rsp_valid_q <= 1'b1;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            be_n_q      <= '1;
            if (TURNAROUND == 0) begin
              state_q     <= S_IDLE;
              req_ready_q <= 1'b1;
            end else begin
              state_q <= S_TURN;
              cnt_q   <= TURN_LOAD;
            end
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        S_TURN: begin
          if (cnt_q == '0) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        S_WR_SETUP: begin
          state_q <= S_WR_PULSE;
          we_n_q  <= 1'b0;
          cnt_q   <= WR_LOAD;
        end
        S_WR_PULSE: begin
          if (cnt_q == '0) begin
            state_q <= S_WR_HOLD;
            we_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        S_WR_HOLD: begin
          state_q     <= S_IDLE;
          ce_n_q      <= 1'b1;
          be_n_q      <= '1;
          dq_oe_q     <= 1'b0;
          rsp_valid_q <= 1'b1;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          ce_n_q      <= 1'b1;
          oe_n_q      <= 1'b1;
          we_n_q      <= 1'b1;
          be_n_q      <= '1;
          dq_oe_q     <= 1'b0;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_be_n_o  = be_n_q;
  assign sram_adr_o   = adr_q;
  assign sram_dq_o    = dq_o_q;
  assign sram_dq_oe_o = dq_oe_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: a pin-level SRAM model behind each DUT and a
// word-level reference memory updated from the request stream.
module tb_sram_ctrl;
  localparam int DW = 16, AW = 8, BW = 2;
  localparam int RW = 1, WW = 1, TA = 1, TA2 = 2;
  localparam int NOBS = 8, NMAX = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic          sel = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_adr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_be = '0;
  logic          va, vb;
  assign va = req_valid & ~sel;
  assign vb = req_valid & sel;

  logic          rdy_a, rv_a, ce_a, oe_a, we_a, dqoe_a;
  logic [DW-1:0] rd_a, dqo_a, dqi_a;
  logic [BW-1:0] ben_a;
  logic [AW-1:0] adr_a;
  logic          rdy_b, rv_b, ce_b, oe_b, we_b, dqoe_b;
  logic [DW-1:0] rd_b, dqo_b, dqi_b;
  logic [BW-1:0] ben_b;
  logic [AW-1:0] adr_b;

  sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_WAIT(RW), .WR_WAIT(WW), .TURNAROUND(TA)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(va), .req_ready_o(rdy_a),
    .req_write_i(req_write), .req_adr_i(req_adr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rv_a), .rsp_rdata_o(rd_a), .sram_ce_n_o(ce_a), .sram_oe_n_o(oe_a),
    .sram_we_n_o(we_a), .sram_be_n_o(ben_a), .sram_adr_o(adr_a), .sram_dq_o(dqo_a),
    .sram_dq_oe_o(dqoe_a), .sram_dq_i(dqi_a));

  sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_WAIT(RW), .WR_WAIT(WW), .TURNAROUND(TA2)) dut_t2 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(vb), .req_ready_o(rdy_b),
    .req_write_i(req_write), .req_adr_i(req_adr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rv_b), .rsp_rdata_o(rd_b), .sram_ce_n_o(ce_b), .sram_oe_n_o(oe_b),
    .sram_we_n_o(we_b), .sram_be_n_o(ben_b), .sram_adr_o(adr_b), .sram_dq_o(dqo_b),
    .sram_dq_oe_o(dqoe_b), .sram_dq_i(dqi_b));

  // Pin-level asynchronous SRAM models.
  logic [DW-1:0] mem_a [0:255];
  logic [DW-1:0] mem_b [0:255];
  assign dqi_a = (!ce_a && !oe_a) ? mem_a[adr_a] : '0;
  assign dqi_b = (!ce_b && !oe_b) ? mem_b[adr_b] : '0;
  always @(negedge clk) begin
    if (rst_n && !ce_a && !we_a && dqoe_a)
      for (int b = 0; b < BW; b++) if (!ben_a[b]) mem_a[adr_a][8*b +: 8] = dqo_a[8*b +: 8];
    if (rst_n && !ce_b && !we_b && dqoe_b)
      for (int b = 0; b < BW; b++) if (!ben_b[b]) mem_b[adr_b][8*b +: 8] = dqo_b[8*b +: 8];
  end

  // Observation of the selected DUT.
  logic          cur_rdy, cur_rv, cur_ce, cur_oe, cur_we, cur_dqoe;
  logic [DW-1:0] cur_rd;
  assign cur_rdy  = sel ? rdy_b  : rdy_a;
  assign cur_rv   = sel ? rv_b   : rv_a;
  assign cur_ce   = sel ? ce_b   : ce_a;
  assign cur_oe   = sel ? oe_b   : oe_a;
  assign cur_we   = sel ? we_b   : we_a;
  assign cur_dqoe = sel ? dqoe_b : dqoe_a;
  assign cur_rd   = sel ? rd_b   : rd_a;

  logic          obs_rdy [NMAX], obs_rv [NMAX], obs_ce [NMAX], obs_oe [NMAX];
  logic          obs_we [NMAX], obs_dqoe [NMAX];
  logic [DW-1:0] obs_rd [NMAX];

  // Reference memory: word-level effect of each write request.
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] last_rd;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic record(input int i);
    obs_rdy[i] = cur_rdy; obs_rv[i] = cur_rv; obs_ce[i] = cur_ce; obs_oe[i] = cur_oe;
    obs_we[i] = cur_we; obs_dqoe[i] = cur_dqoe; obs_rd[i] = cur_rd;
  endtask

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!cur_rdy && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (cur_rdy !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: req_ready=%b after %0d cycles, need 1", cur_rdy, t);
    end
  endtask

  // Issues one request; index i of obs_* is the cycle following edge Ei.
  // A read is pulsed at index 'poke' while the controller is busy.
  task automatic run_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] be, input int poke);
    wait_ready();
    req_write = wr; req_adr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int i = 0; i < NOBS; i++) begin
      @(negedge clk);
      record(i);
      req_valid = (i == poke);
      if (i == poke) begin req_write = 1'b0; req_adr = a + 8'd1; end
    end
    req_valid = 1'b0;
    if (wr) ref_mem[a] = merge(ref_mem[a], d, be);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 10;
    if (ce_a !== 1'b1)    begin errors++; $display("FAIL rst_ce_n: got %b need 1", ce_a); end
    if (oe_a !== 1'b1)    begin errors++; $display("FAIL rst_oe_n: got %b need 1", oe_a); end
    if (we_a !== 1'b1)    begin errors++; $display("FAIL rst_we_n: got %b need 1", we_a); end
    if (ben_a !== 2'b11)  begin errors++; $display("FAIL rst_be_n: got %b need 11", ben_a); end
    if (dqoe_a !== 1'b0)  begin errors++; $display("FAIL rst_dq_oe: got %b need 0", dqoe_a); end
    if (adr_a !== '0)     begin errors++; $display("FAIL rst_adr: got %h need 00", adr_a); end
    if (dqo_a !== '0)     begin errors++; $display("FAIL rst_dq_o: got %h need 0000", dqo_a); end
    if (rd_a !== '0)      begin errors++; $display("FAIL rst_rdata: got %h need 0000", rd_a); end
    if (rv_a !== 1'b0)    begin errors++; $display("FAIL rst_rsp_valid: got %b need 0", rv_a); end
    if (rdy_a !== 1'b0)   begin errors++; $display("FAIL rst_req_ready: got %b need 0", rdy_a); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy_a !== 1'b0) begin errors++; $display("FAIL rst_ready_early: got %b need 0", rdy_a); end
    @(negedge clk);
    checks++;
    if (rdy_a !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b need 1", rdy_a); end
  endtask

  task automatic test_write();
    sel = 1'b0;
    run_access(1'b1, 8'h12, 16'hBEEF, 2'b11, -1);
    for (int i = 0; i < NOBS; i++) begin
      checks += 4;
      if (obs_we[i] !== !(i >= 1 && i <= WW + 1)) begin errors++; $display("FAIL wr_we_n[%0d]: got %b", i, obs_we[i]); end
      if (obs_dqoe[i] !== (i <= WW + 2)) begin errors++; $display("FAIL wr_dq_oe[%0d]: got %b", i, obs_dqoe[i]); end
      if (obs_rv[i] !== (i == WW + 3)) begin errors++; $display("FAIL wr_rsp_valid[%0d]: got %b", i, obs_rv[i]); end
      if (obs_rdy[i] !== (i >= WW + 3)) begin errors++; $display("FAIL wr_req_ready[%0d]: got %b", i, obs_rdy[i]); end
    end
    checks++;
    if (mem_a[8'h12] !== 16'hBEEF) begin errors++; $display("FAIL wr_mem: got %h need beef", mem_a[8'h12]); end
  endtask

  task automatic test_read();
    sel = 1'b0;
    run_access(1'b0, 8'h12, 16'h0000, 2'b00, -1);
    for (int i = 0; i < NOBS; i++) begin
      checks += 3;
      if (obs_oe[i] !== !(i <= RW)) begin errors++; $display("FAIL rd_oe_n[%0d]: got %b", i, obs_oe[i]); end
      if (obs_rv[i] !== (i == RW + 1)) begin errors++; $display("FAIL rd_rsp_valid[%0d]: got %b", i, obs_rv[i]); end
      if (obs_rdy[i] !== (i >= RW + 1 + TA)) begin errors++; $display("FAIL rd_req_ready[%0d]: got %b", i, obs_rdy[i]); end
    end
    checks++;
    if (obs_rd[RW + 1] !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h need beef", obs_rd[RW + 1]); end
  endtask

  task automatic test_byte_lane();
    int nrv;
    sel = 1'b0;
    run_access(1'b1, 8'h05, 16'h1234, 2'b11, -1);
    run_access(1'b1, 8'h05, 16'hAB00, 2'b10, 1);
    nrv = 0;
    for (int i = 0; i < NOBS; i++) begin
      nrv += int'(obs_rv[i]);
      checks++;
      if (obs_oe[i] !== 1'b1) begin errors++; $display("FAIL busy_oe_n[%0d]: got %b need 1", i, obs_oe[i]); end
    end
    checks += 2;
    if (obs_rdy[1] !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b need 0", obs_rdy[1]); end
    if (nrv != 1) begin errors++; $display("FAIL busy_rsp_count: got %0d need 1", nrv); end
    run_access(1'b0, 8'h05, 16'h0000, 2'b00, -1);
    checks++;
    if (obs_rd[RW + 1] !== 16'hAB34) begin errors++; $display("FAIL lane_read: got %h need ab34", obs_rd[RW + 1]); end
    last_rd = 16'hAB34;
  endtask

  task automatic test_random();
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
    sel = 1'b0;
    for (int k = 0; k < 16; k++) run_access(1'b1, AW'(k), DW'($urandom), 2'b11, -1);
    for (int n = 0; n < 40; n++) begin
      wr = 1'(($urandom % 2));
      a  = AW'($urandom_range(0, 15));
      d  = DW'($urandom);
      be = BW'($urandom);
      run_access(wr, a, d, be, -1);
      for (int i = 0; i < NOBS; i++) begin
        checks += 2;
        if (obs_rv[i] !== (wr ? (i == WW + 3) : (i == RW + 1)))
          begin errors++; $display("FAIL rnd_rsp_valid[%0d] n=%0d wr=%b: got %b", i, n, wr, obs_rv[i]); end
        if (obs_oe[i] === 1'b0 && obs_we[i] === 1'b0)
          begin errors++; $display("FAIL rnd_strobe_overlap[%0d] n=%0d: oe_n=0 we_n=0", i, n); end
      end
      checks++;
      if (wr) begin
        if (obs_rd[NOBS - 1] !== last_rd)
          begin errors++; $display("FAIL rnd_rdata_held n=%0d: got %h need %h", n, obs_rd[NOBS - 1], last_rd); end
      end else begin
        if (obs_rd[RW + 1] !== ref_mem[a])
          begin errors++; $display("FAIL rnd_read n=%0d adr=%h: got %h need %h", n, a, obs_rd[RW + 1], ref_mem[a]); end
        last_rd = ref_mem[a];
      end
    end
  endtask

  task automatic test_back_to_back();
    int last_oe, first_dq, nrv;
    sel = 1'b1;
    run_access(1'b1, 8'h20, 16'h7E57, 2'b11, -1);
    wait_ready();
    req_write = 1'b0; req_adr = 8'h20; req_valid = 1'b1;
    @(posedge clk); #1;
    req_write = 1'b1; req_adr = 8'h21; req_wdata = 16'hC0DE; req_be = 2'b11;
    for (int i = 0; i < NMAX; i++) begin
      @(negedge clk);
      record(i);
      if (cur_dqoe) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    last_oe = -1; first_dq = -1; nrv = 0;
    for (int i = 0; i < NMAX; i++) begin
      if (obs_oe[i] === 1'b0) last_oe = i;
      if (obs_dqoe[i] === 1'b1 && first_dq < 0) first_dq = i;
      nrv += int'(obs_rv[i]);
      checks += 2;
      if ((obs_oe[i] === 1'b0 && obs_we[i] === 1'b0) || (obs_dqoe[i] === 1'b1 && obs_oe[i] === 1'b0))
        begin errors++; $display("FAIL b2b_invariant[%0d]: oe_n=%b we_n=%b dq_oe=%b", i, obs_oe[i], obs_we[i], obs_dqoe[i]); end
      if (i > 0 && obs_rv[i] === 1'b1 && obs_rv[i-1] === 1'b1)
        begin errors++; $display("FAIL b2b_rsp_twice[%0d]: rsp_valid high two cycles", i); end
    end
    checks += 6;
    if (last_oe != RW) begin errors++; $display("FAIL b2b_last_oe: got %0d need %0d", last_oe, RW); end
    if (first_dq != RW + 1 + TA2 + 1) begin errors++; $display("FAIL b2b_first_dq: got %0d need %0d", first_dq, RW + TA2 + 2); end
    if (first_dq - last_oe - 1 < TA2) begin errors++; $display("FAIL b2b_gap: got %0d need >= %0d", first_dq - last_oe - 1, TA2); end
    if (obs_rd[RW + 1] !== 16'h7E57) begin errors++; $display("FAIL b2b_read: got %h need 7e57", obs_rd[RW + 1]); end
    if (nrv != 2) begin errors++; $display("FAIL b2b_rsp_count: got %0d need 2", nrv); end
    if (mem_b[8'h21] !== 16'hC0DE) begin errors++; $display("FAIL b2b_mem: got %h need c0de", mem_b[8'h21]); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    sel = 1'b0;
    wait_ready();
    req_write = 1'b1; req_adr = 8'h30; req_wdata = 16'hFFFF; req_be = 2'b11; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (we_a !== 1'b0) begin errors++; $display("FAIL mid_pulse: we_n=%b need 0", we_a); end
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (we_a !== 1'b1)   begin errors++; $display("FAIL mid_we_n: got %b need 1", we_a); end
    if (ce_a !== 1'b1)   begin errors++; $display("FAIL mid_ce_n: got %b need 1", ce_a); end
    if (dqoe_a !== 1'b0) begin errors++; $display("FAIL mid_dq_oe: got %b need 0", dqoe_a); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rv_a !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid[%0d]: got %b need 0", i, rv_a); end
    end
    run_access(1'b1, 8'h31, 16'h5A5A, 2'b11, -1);
    checks++;
    if (obs_rv[WW + 3] !== 1'b1) begin errors++; $display("FAIL mid_after_rsp: got %b need 1", obs_rv[WW + 3]); end
    run_access(1'b0, 8'h31, 16'h0000, 2'b00, -1);
    checks++;
    if (obs_rd[RW + 1] !== ref_mem[8'h31])
      begin errors++; $display("FAIL mid_after_read: got %h need %h", obs_rd[RW + 1], ref_mem[8'h31]); end
  endtask

  initial begin
    last_rd = '0;
    test_reset();
    test_write();
    test_read();
    test_byte_lane();
    test_random();
    test_back_to_back();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors + 1, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
